// File: rtl/serial_pattern_pkg.sv
// Shared sync-pattern constants and transmitter state encoding.
// The recognizer imports the same header constants.
package serial_pattern_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_PAR,
        S_GAP
    } tx_state_t;

    localparam int unsigned SYNC_HEADER_W = 8;
    localparam logic [SYNC_HEADER_W-1:0] SYNC_HEADER = 8'b11111101;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, MSB-first shift register with zero fill; serial out is the MSB.
module tx_shift_reg #(
    parameter int unsigned W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         so_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign so_o = sr_q[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: sync header, payload MSB first, then GAP idle zeros.
// Optional even-parity bit after the payload: define SERIAL_PATTERN_TX_PARITY_EN.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int unsigned           DATA_W   = 8,
    parameter int unsigned           HEADER_W = SYNC_HEADER_W,
    parameter logic [HEADER_W-1:0]   HEADER   = HEADER_W'(SYNC_HEADER),
    parameter int unsigned           GAP      = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Load,
    input  logic [DATA_W-1:0] Data,
    output logic              Ready,
    output logic              DataOut,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned CNT_W = $clog2(max3(HEADER_W, DATA_W, GAP) + 1);

    localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(HEADER_W - 1);
    localparam logic [CNT_W-1:0] BODY_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int unsigned FRAME_W      = HEADER_W + DATA_W + 1;
    localparam bit          DONE_ON_BODY = 1'b0;
`else
    localparam int unsigned FRAME_W      = HEADER_W + DATA_W;
    localparam bit          DONE_ON_BODY = 1'b1;
`endif

    tx_state_t          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               accept;
    logic               shift;
    logic [FRAME_W-1:0] frame;

    // The whole frame is loaded at acceptance, so the shifter MSB is already the
    // first header bit in the next cycle and zero fill yields the idle/gap level.
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign frame = {HEADER, Data, ^Data};
`else
    assign frame = {HEADER, Data};
`endif

    assign Ready  = (state_q == S_IDLE);
    assign accept = Load && Ready;
    assign shift  = (state_q != S_IDLE) && (state_q != S_GAP);

    tx_shift_reg #(
        .W (FRAME_W)
    ) u_shift (
        .Clock   (Clock),
        .Reset   (Reset),
        .load_i  (accept),
        .shift_i (shift),
        .data_i  (frame),
        .so_o    (DataOut)
    );

    // cnt_q counts down the remaining bits of the current phase
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= S_HEAD;
                        cnt_q   <= HEAD_LAST;
                        busy_q  <= 1'b1;
                    end
                end
                S_HEAD: begin
                    if (cnt_q == '0) begin
                        state_q <= S_BODY;
                        cnt_q   <= BODY_LAST;
                        done_q  <= DONE_ON_BODY && (DATA_W == 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_BODY: begin
                    if (cnt_q == '0) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        state_q <= S_PAR;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
`else
                        state_q <= S_GAP;
                        cnt_q   <= GAP_LAST;
                        done_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        done_q <= DONE_ON_BODY && (cnt_q == CNT_ONE);
                    end
                end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                S_PAR: begin
                    state_q <= S_GAP;
                    cnt_q   <= GAP_LAST;
                    done_q  <= 1'b0;
                end
`endif
                S_GAP: begin
                    done_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx (default parameters).
// Honours SERIAL_PATTERN_TX_PARITY_EN to match the DUT build.
module tb_serial_pattern_tx;

    localparam logic [7:0] HDR = 8'b11111101;
    localparam int         GAPN = 1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int         FL = 17;
`else
    localparam int         FL = 16;
`endif

    logic       Clock;
    logic       Reset;
    logic       Load;
    logic [7:0] Data;
    logic       Ready;
    logic       DataOut;
    logic       Busy;
    logic       Done;

    int nvec = 0;
    int nmis = 0;

    serial_pattern_tx #(
        .DATA_W   (8),
        .HEADER_W (8),
        .HEADER   (8'b11111101),
        .GAP      (1)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Load    (Load),
        .Data    (Data),
        .Ready   (Ready),
        .DataOut (DataOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one word for a single accepting edge, then drop Load.
    task automatic start(input logic [7:0] d);
        @(negedge Clock);
        Load = 1'b1;
        Data = d;
        @(posedge Clock);
        #1 Load = 1'b0;
    endtask

    // Called right after the accepting edge; checks frame bits and the gap.
    task automatic check_frame(input string name, input logic [7:0] d, input logic p);
        logic [16:0] fr;
        fr = {HDR, d, p};
        for (int i = 0; i < FL; i++) begin
            @(negedge Clock);
            check_vec($sformatf("%s_bit%0d", name, i), {31'd0, DataOut}, {31'd0, fr[16-i]});
            check_vec($sformatf("%s_done%0d", name, i), {31'd0, Done}, {31'd0, i == FL-1});
            check_vec($sformatf("%s_busy%0d", name, i), {31'd0, Busy}, 32'd1);
            check_vec($sformatf("%s_rdy%0d", name, i), {31'd0, Ready}, 32'd0);
        end
        for (int g = 0; g < GAPN; g++) begin
            @(negedge Clock);
            check_vec($sformatf("%s_gapbit%0d", name, g), {31'd0, DataOut}, 32'd0);
            check_vec($sformatf("%s_gapbusy%0d", name, g), {31'd0, Busy}, 32'd1);
            check_vec($sformatf("%s_gapdone%0d", name, g), {31'd0, Done}, 32'd0);
            check_vec($sformatf("%s_gaprdy%0d", name, g), {31'd0, Ready}, 32'd0);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge Clock);
        check_vec({name, "_idle_rdy"}, {31'd0, Ready}, 32'd1);
        check_vec({name, "_idle_busy"}, {31'd0, Busy}, 32'd0);
        check_vec({name, "_idle_dout"}, {31'd0, DataOut}, 32'd0);
    endtask

    initial begin
        logic [7:0] win;
        Reset = 1'b0;
        Load  = 1'b0;
        Data  = 8'h00;
        repeat (2) @(negedge Clock);
        check_vec("rst_dout", {31'd0, DataOut}, 32'd0);
        check_vec("rst_busy", {31'd0, Busy}, 32'd0);
        check_vec("rst_done", {31'd0, Done}, 32'd0);
        check_vec("rst_rdy", {31'd0, Ready}, 32'd1);
        Reset = 1'b1;
        @(negedge Clock);

        // A5 frame; Load/Data disturbed mid-frame must be ignored.
        start(8'hA5);
        fork
            check_frame("a5", 8'hA5, 1'b0);
            begin
                repeat (4) @(negedge Clock);
                Load = 1'b1;
                Data = 8'h3C;
                repeat (6) @(negedge Clock);
                Load = 1'b0;
            end
        join
        check_idle("a5");
        repeat (3) @(negedge Clock);
        check_vec("a5_no_extra_busy", {31'd0, Busy}, 32'd0);
        check_vec("a5_no_extra_dout", {31'd0, DataOut}, 32'd0);

        // Sync window over the serial stream with an all-zero payload.
        win = 8'h00;
        start(8'h00);
        for (int i = 0; i < FL + GAPN; i++) begin
            @(negedge Clock);
            win = {win[6:0], DataOut};
            check_vec($sformatf("sync_win%0d", i), {31'd0, win == HDR}, {31'd0, i == 7});
        end
        check_idle("z");

        // Load held high: FF then 0F back-to-back, Data changed mid-frame.
        @(negedge Clock);
        Load = 1'b1;
        Data = 8'hFF;
        @(posedge Clock);
        #1 Data = 8'h0F;
        check_frame("ff", 8'hFF, 1'b0);
        check_idle("ff");
        @(posedge Clock);
        #1 Data = 8'hAA;
        fork
            check_frame("0f", 8'h0F, 1'b0);
            begin
                repeat (3) @(negedge Clock);
                Load = 1'b0;
            end
        join
        check_idle("0f");

        // Reset during the 4th payload bit of F0 (that bit is 1).
        start(8'hF0);
        repeat (8 + 4) @(negedge Clock);
        check_vec("mid_pre_dout", {31'd0, DataOut}, 32'd1);
        Reset = 1'b0;
        #1;
        check_vec("mid_rst_dout", {31'd0, DataOut}, 32'd0);
        check_vec("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check_vec("mid_rst_rdy", {31'd0, Ready}, 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        check_idle("mid_rel");
        start(8'h5A);
        check_frame("5a", 8'h5A, 1'b0);
        check_idle("5a");

        // Odd-weight payload: parity bit 1 when enabled.
        start(8'h07);
        check_frame("07", 8'h07, 1'b1);
        check_idle("07");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial frame transmitter: accepts one parallel word per handshake and emits a frame on DataOut, one bit per Clock.
- Frame format: fixed sync header (default 11111101, MSB first), then the payload MSB first, then an idle gap of zeros.
- Drives the sync-pattern recognizer on the chip-under-test input.
- The header marks frame start; zeros between frames keep the recognizer's sequence tracker cleared.

Parameters:
- DATA_W, 8, payload width in bits; legal range 1..32.
- HEADER_W, 8, sync header width in bits; legal range 1..16.
- HEADER, 8'b11111101, sync header value, sent MSB first.
- GAP, 1, number of idle zero bits after each frame; legal range 1..15.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Load  input  1  request valid; the word is accepted when Load && Ready.
- Data  input  DATA_W  payload; sampled only on the accepting edge.
- Ready  output  1  high only in IDLE; combinational from state.
- DataOut  output  1  serial bit stream; registered.
- Busy  output  1  high from the first header bit through the last gap bit; registered.
- Done  output  1  one-cycle pulse, coincident with the last payload bit (or the parity bit); registered.

Behaviour:
- Reset (asynchronous, active-low) values:
  - state IDLE, bit counter 0, shift register 0.
  - DataOut 0, Busy 0, Done 0; Ready 1.
- States: IDLE, HEAD, BODY, [PAR], GAP.
- IDLE: DataOut 0. On Load && Ready at edge N:
  - Data is captured into the shift register.
  - Move to HEAD.
  - DataOut = HEADER[HEADER_W-1] and Busy = 1 from edge N.
  - So the first header bit is valid in cycle N+1, i.e. one cycle of latency.
- HEAD: drives HEADER_W bits MSB first. After bit HEADER_W-1, move to BODY; no idle cycle between header and payload.
- BODY: drives DATA_W bits MSB first, shifting left each cycle.
  - The last bit asserts Done for exactly that cycle.
  - Then move to GAP (or to PAR when PARITY_EN is defined).
- GAP: DataOut 0 for GAP cycles, Busy 1, Ready 0, then IDLE.
  - The minimum frame-to-frame spacing is therefore HEADER_W + DATA_W + GAP + 1 cycles.
- Load while Ready = 0 is ignored; no queuing, and Data is not sampled.
- Data changes after acceptance have no effect on the frame in flight.
- One counter, width $clog2(max(HEADER_W, DATA_W, GAP) + 1), reloads on every state change. No wrap beyond its terminal count.
- Reset asserted mid-frame: the frame is aborted immediately and DataOut goes to 0. After release, the block is in IDLE with Ready = 1; no partial frame is resumed.
- Load held high continuously: one frame is sent per accepted word, back-to-back separated only by GAP zeros plus the one IDLE cycle.
- Payload contents are not checked. A payload containing the header pattern is transmitted unchanged; avoiding it is the sender's job.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - PAR state inserted after BODY; drives one even-parity bit (XOR of the captured payload).
  - Done moves from the last payload bit to the parity bit.
  - Frame length becomes HEADER_W + DATA_W + 1.
- Undefined: no PAR state, no parity logic; frame length is HEADER_W + DATA_W.

Decomposition:
- Package serial_pattern_pkg:
  - tx_state_t enum (IDLE, HEAD, BODY, PAR, GAP).
  - SYNC_HEADER = 8'b11111101.
  - SYNC_HEADER_W = 8.
  - The recognizer shares these constants.
- One sub-module, tx_shift_reg: parallel-load, MSB-first shift register with load and shift enables and a serial out.
- The FSM, counter and output registers stay in serial_pattern_tx.

Test Plan:
- Reset, then Load = 1 with Data = 8'hA5 for one cycle:
  - DataOut over 16 cycles = 1,1,1,1,1,1,0,1, 1,0,1,0,0,1,0,1.
  - Done high only in the 16th cycle; Busy high for 17 cycles; Ready low from the cycle after acceptance until IDLE.
- Loopback into the recognizer with Data = 8'h00: MatchAll high exactly one cycle after the 8th header bit, and low through the payload.
- Load held high with Data = 8'hFF then 8'h0F: two frames separated by exactly GAP + 1 zero cycles. The second payload is 00001111, unaffected by Data changes mid-frame.
- Reset pulsed low during the 4th payload bit: DataOut 0 immediately, Ready 1 after release. The next Load starts a fresh header.
- Load asserted while Busy = 1: ignored; no extra frame, and the current frame is unchanged.
- PARITY_EN defined, Data = 8'hA5 (four ones): parity bit 0 in cycle 17; Done moves to cycle 17. With Data = 8'h07, parity bit is 1.
